// File: rtl/punc_exec_pkg.sv
// Shared opcodes and FSM state encoding for the PUnC execute stage.
package punc_exec_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_XOR  = 4'd3;
  localparam logic [3:0] OP_NOT  = 4'd4;
  localparam logic [3:0] OP_PASS = 4'd5;
  localparam logic [3:0] OP_SHL  = 4'd6;
  localparam logic [3:0] OP_SHR  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;

  typedef enum logic [0:0] {
    StIdle,
    StMul
  } state_e;

endpackage

// File: rtl/punc_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; low DATA_W bits of the product.
module punc_mul_iter #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] product
);

  localparam int unsigned CntW = $clog2(DATA_W);

  logic [DATA_W-1:0] mcand_q, mplier_q, acc_q, acc_next;
  logic [CntW-1:0]   cnt_q;
  logic              run_q;

  // product includes the step being taken this cycle so the final bit needs no extra cycle
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product  = acc_next;
  assign done     = run_q && (cnt_q == CntW'(DATA_W - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_next;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/punc_exec_unit.sv
// Registered execute stage with valid/ready handshakes, condition codes and iterative multiply.
module punc_exec_unit
  import punc_exec_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter bit          MUL_EN = 1'b1,
  parameter int unsigned SH_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        imm5,
  input  logic              imm_sel,
  input  logic              cc_ld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              n,
  output logic              z,
  output logic              p,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              out_valid_q, out_valid_d;
  logic              n_q, n_d, z_q, z_d, p_q, p_d;
  logic              cc_ld_q, cc_ld_d;

  logic [DATA_W-1:0] b_eff, alu_res, load_val, mul_product;
  logic [SH_W-1:0]   sh;
  logic              accept, load, load_cc, mul_start, mul_done;

  assign b_eff  = imm_sel ? {{(DATA_W-5){imm5[4]}}, imm5} : b;
  assign sh     = b_eff[SH_W-1:0];
  assign busy   = (state_q == StMul);
  assign in_ready = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept = in_valid && in_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = a + b_eff;
      OP_SUB:  alu_res = a - b_eff;
      OP_AND:  alu_res = a & b_eff;
      OP_XOR:  alu_res = a ^ b_eff;
      OP_NOT:  alu_res = ~a;
      OP_PASS: alu_res = a;
      OP_SHL:  alu_res = a << sh;
      OP_SHR:  alu_res = a >> sh;
      OP_SRA:  alu_res = DATA_W'($signed(a) >>> sh);
      default: alu_res = '0;  // also OP_MUL when the multiplier is not built
    endcase
  end

  if (MUL_EN) begin : g_mul
    punc_mul_iter #(
      .DATA_W(DATA_W)
    ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (mul_start),
      .a      (a),
      .b      (b_eff),
      .done   (mul_done),
      .product(mul_product)
    );
  end else begin : g_no_mul
    assign mul_done    = 1'b0;
    assign mul_product = '0;
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    out_valid_d = out_valid_q;
    cc_ld_d     = cc_ld_q;
    n_d         = n_q;
    z_d         = z_q;
    p_d         = p_q;
    load        = 1'b0;
    load_cc     = 1'b0;
    load_val    = '0;
    mul_start   = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cc_ld_d = cc_ld;
          if (MUL_EN && (op == OP_MUL)) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            load     = 1'b1;
            load_val = alu_res;
            load_cc  = cc_ld;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          state_d  = StIdle;
          load     = 1'b1;
          load_val = mul_product;
          load_cc  = cc_ld_q;
        end
      end
      default: state_d = StIdle;
    endcase

    // a fresh load wins over the handshake clear, giving back-to-back throughput
    if (load) begin
      result_d    = load_val;
      out_valid_d = 1'b1;
      if (load_cc) begin
        n_d = load_val[DATA_W-1];
        z_d = (load_val == '0);
        p_d = !load_val[DATA_W-1] && (load_val != '0);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      cc_ld_q     <= 1'b0;
      n_q         <= 1'b0;
      z_q         <= 1'b0;
      p_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      cc_ld_q     <= cc_ld_d;
      n_q         <= n_d;
      z_q         <= z_d;
      p_q         <= p_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign n         = n_q;
  assign z         = z_q;
  assign p         = p_q;

endmodule

// File: tb/tb_punc_exec_unit.sv
// Directed bench for punc_exec_unit with an in-order expected-result scoreboard.
module tb_punc_exec_unit;
  import punc_exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic [4:0]  imm5;
  logic        imm_sel, cc_ld;
  logic        out_valid, out_ready;
  logic [15:0] result;
  logic        n, z, p, busy;

  always #5 clk = ~clk;

  punc_exec_unit #(
    .DATA_W(16),
    .MUL_EN(1'b1),
    .SH_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .imm5     (imm5),
    .imm_sel  (imm_sel),
    .cc_ld    (cc_ld),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .n        (n),
    .z        (z),
    .p        (p),
    .busy     (busy)
  );

  typedef struct {
    logic [15:0] res;
    logic        n, z, p;
  } exp_t;

  exp_t sb[$];
  logic mn, mz, mp;
  int   checks = 0;
  int   fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [3:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    logic signed [15:0] sx;
    logic [31:0]        prod;
    sx   = x;
    prod = x * y;
    case (o)
      OP_ADD:  return x + y;
      OP_SUB:  return x - y;
      OP_AND:  return x & y;
      OP_XOR:  return x ^ y;
      OP_NOT:  return ~x;
      OP_PASS: return x;
      OP_SHL:  return x << y[3:0];
      OP_SHR:  return x >> y[3:0];
      OP_SRA:  return sx >>> y[3:0];
      OP_MUL:  return prod[15:0];
      default: return 16'h0000;
    endcase
  endfunction

  // Drive one op, push its expected outcome, and return #1 after the accepting edge.
  task automatic issue(input logic [3:0] o, input logic [15:0] av, input logic [15:0] bv,
                       input logic [4:0] im, input logic isel, input logic cc);
    logic [15:0] bp, r;
    exp_t        e;
    int          guard;
    op = o; a = av; b = bv; imm5 = im; imm_sel = isel; cc_ld = cc; in_valid = 1'b1;
    bp = isel ? {{11{im[4]}}, im} : bv;
    r  = model(o, av, bp);
    if (cc) begin
      mn = r[15];
      mz = (r == 16'h0);
      mp = !r[15] && (r != 16'h0);
    end
    e.res = r; e.n = mn; e.z = mz; e.p = mp;
    sb.push_back(e);
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, sb.size(), 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_n"}, n, e.n);
      chk({tag, "_z"}, z, e.z);
      chk({tag, "_p"}, p, e.p);
    end
  endtask

  task automatic wait_out(input string tag, input int maxc, output int lat, output int busy_n);
    lat    = 1;
    busy_n = 0;
    while (!out_valid && lat < maxc) begin
      if (busy && !in_ready) busy_n++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    compare_out(tag);
  endtask

  initial begin
    int lat, bn, seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    op = 4'h0; a = '0; b = '0; imm5 = '0; imm_sel = 1'b0; cc_ld = 1'b0;
    mn = 1'b0; mz = 1'b0; mp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_nzp", {n, z, p}, 3'b000);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    issue(OP_ADD, 16'h0005, 16'h0003, 5'h00, 1'b0, 1'b1);
    wait_out("add", 5, lat, bn);
    chk("add_lat", lat, 1);

    issue(OP_SUB, 16'h0002, 16'h0000, 5'h03, 1'b1, 1'b1);
    wait_out("sub_imm3", 5, lat, bn);
    issue(OP_SUB, 16'h0002, 16'h0000, 5'h02, 1'b1, 1'b1);
    wait_out("sub_imm2", 5, lat, bn);
    issue(OP_SUB, 16'h0002, 16'h0000, 5'h1F, 1'b1, 1'b1);
    wait_out("sub_immm1", 5, lat, bn);

    issue(OP_MUL, 16'h0123, 16'h0010, 5'h00, 1'b0, 1'b1);
    wait_out("mul1", 40, lat, bn);
    chk("mul1_lat", lat, 17);
    chk("mul1_busy_cycles", bn, 16);
    issue(OP_MUL, 16'hFFFF, 16'hFFFF, 5'h00, 1'b0, 1'b1);
    wait_out("mul2", 40, lat, bn);
    chk("mul2_lat", lat, 17);

    issue(OP_SRA, 16'h8000, 16'h0004, 5'h00, 1'b0, 1'b1);
    wait_out("sra", 5, lat, bn);
    issue(OP_SHR, 16'h8000, 16'h0004, 5'h00, 1'b0, 1'b1);
    wait_out("shr", 5, lat, bn);
    issue(OP_SHL, 16'h0001, 16'h000F, 5'h00, 1'b0, 1'b1);
    wait_out("shl", 5, lat, bn);

    issue(4'hF, 16'h1234, 16'h5678, 5'h00, 1'b0, 1'b1);
    wait_out("undef_op", 5, lat, bn);

    // backpressure: drain, then hold an ADD result with out_ready low
    @(posedge clk);
    #1;
    chk("drain_valid", out_valid, 0);
    out_ready = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0002, 5'h00, 1'b0, 1'b1);
    wait_out("bp_add", 5, lat, bn);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_result", result, 16'h0003);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    issue(OP_XOR, 16'hF0F0, 16'h0FF0, 5'h00, 1'b0, 1'b0);
    chk("bp_no_bubble", out_valid, 1);
    compare_out("bp_xor");

    // reset five cycles into a multiply
    issue(OP_MUL, 16'h0003, 16'h0005, 5'h00, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_result", result, 0);
    chk("mrst_nzp", {n, z, p}, 3'b000);
    sb.delete();
    mn = 1'b0; mz = 1'b0; mp = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("mrst_no_valid", seen, 0);

    issue(OP_ADD, 16'hFFFE, 16'h0001, 5'h00, 1'b0, 1'b1);
    wait_out("post_rst_add", 5, lat, bn);
    issue(OP_PASS, 16'h0000, 16'h0000, 5'h00, 1'b0, 1'b0);
    wait_out("cc_hold_pass", 5, lat, bn);

    @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
